stall_mem_resp: RTL
===================

# stall_mem_resp

Multi-cycle data-memory responder that sits on the far side of the memory-stage request interface (enable/wr/addr/data_in). It replaces single-cycle memory with a fixed-latency responder. It accepts one request at a time, holds the pipeline with `stall` while the access is in flight, and signals completion with a one-cycle `done` pulse carrying read data.

## Interface
- `LATENCY`, 4: cycles from request acceptance to the `done` cycle; legal values are ≥2.
- `DEPTH`, 1024: number of 16-bit words; must be a power of 2.
- `clk` input, 1: single clock; all state updates on rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `enable` input, 1: a request is present this cycle.
- `wr` input, 1: 1 = write, 0 = read; sampled only with `enable`.
- `addr` input, 16: byte address; word index = `addr[15:1]` modulo `DEPTH`.
- `data_in` input, 16: write data; sampled only with `enable & wr`.
- `data_out` output, 16: read data, registered; valid in the `done` cycle.
- `stall` output, 1: requester must hold its request and freeze.
- `done` output, 1: one-cycle completion pulse.
- `err` output, 1: misaligned-access flag; present only with `MEM_ALIGN_CHK_EN`.

Clock and reset: one clock; reset is synchronous and active-high (ports `clk`, `rst`).

## Operation
- FSM has three states: IDLE, BUSY, DONE. DONE lasts exactly one cycle.
- Acceptance: the request is accepted at the edge where the state is IDLE or DONE and `enable`=1.
  - `wr`, `addr` and `data_in` are latched.
  - The counter loads `LATENCY-1` and the state moves to BUSY.
- BUSY: the counter decrements every edge. At the edge where the counter equals 1, the access completes and the state moves to DONE.
- Completion:
  - Write: commits `data_in` to the array.
  - Read: loads the array word into `data_out`.
  - Write completion leaves `data_out` unchanged.
- DONE: `done`=1. If `enable`=1 the next request is accepted (back-to-back); otherwise the state returns to IDLE.
- `enable` is ignored while BUSY. Latched values are not resampled, so input changes during BUSY have no effect.
- `stall` = (state==BUSY) | (`enable` & state∈{IDLE,DONE}). It is combinational, so it is high in the request cycle itself. It is low in the `done` cycle unless a new request is presented in that cycle.
- A back-to-back read of an address written by the previous request returns the new data, because the write commits before the read is accepted.
- Address wrap: index bits above log2(`DEPTH`) are dropped.
- Reset (including mid-operation):
  - State → IDLE, counter → 0, `data_out` → 0, `done` → 0, `err` → 0.
  - An in-flight write is aborted and not committed.
  - Array contents are not cleared.

## Timing
- Request presented in cycle 0 (accepted at the end of cycle 0).
- `stall` is high in cycles 0 through `LATENCY-1`.
- `done` and `data_out` are valid in cycle `LATENCY`.
- Maximum throughput: one request per `LATENCY` cycles.
- Reset values: `stall` = `enable` (IDLE); `done`=0; `data_out`=0; `err`=0.

## Configuration
- `MEM_ALIGN_CHK_EN` defined:
  - A request with `addr[0]`=1 follows normal latency.
  - `err` pulses together with `done`.
  - A write is suppressed, and a read returns `data_out`=0.
- `MEM_ALIGN_CHK_EN` undefined:
  - No `err` port.
  - `addr[0]` is ignored; the access proceeds to word `addr[15:1]`.

## Structure
- Package `stall_mem_pkg`:
  - State enum `mem_state_t` (IDLE, BUSY, DONE).
  - `DEF_LATENCY`=4 and `DEF_DEPTH`=1024.
  - Counter width function `$clog2(LATENCY)`.
- Sub-module `stall_mem_array`: single-port synchronous array (we, index, wdata, rdata) with no reset.
  - The top level owns the FSM, counter, request latches and `data_out` register.

## Test plan
- Reset, then write 0xBEEF to addr 0x0010 with `LATENCY`=4 → `stall`=1 in cycles 0–3, `done`=1 only in cycle 4, `data_out` stays 0.
- Read addr 0x0010 → `done` in cycle 4 with `data_out`=0xBEEF; `data_out` holds 0xBEEF afterwards.
- Write 0x1234 to 0x0020, then present a read of 0x0020 in the `done` cycle → read accepted with no gap; returns 0x1234 four cycles later.
- Change `addr`/`data_in` during BUSY of a write to 0x0030 (data 0x00AA) → 0x00AA lands at 0x0030; the changed values are ignored.
- Assert `rst` in cycle 2 of a write of 0x5555 to 0x0040 → `done` never pulses; a later read of 0x0040 returns the old value; `data_out`=0 after reset.
- With `MEM_ALIGN_CHK_EN`, write 0x7777 to 0x0041 → `err`=`done`=1 in cycle 4; a read of 0x0040 returns the old value. Without the macro, 0x7777 lands in word 0x0040.

Source files
------------

// File: rtl/stall_mem_pkg.sv
// Shared types and defaults for the fixed-latency data-memory responder.
package stall_mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mem_state_t;

  localparam int unsigned DEF_LATENCY = 4;
  localparam int unsigned DEF_DEPTH   = 1024;

  function automatic int unsigned cnt_width(input int unsigned latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/stall_mem_array.sv
// Single-port 16-bit word array: synchronous write, combinational read, no reset.
module stall_mem_array #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned IdxW  = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic [15:0]     wdata_i,
  output logic [15:0]     rdata_o
);

  logic [15:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/stall_mem_resp.sv
// Fixed-latency memory responder: holds the requester with stall, pulses done on completion.
// Optional misaligned-access flag `err` is built when MEM_ALIGN_CHK_EN is defined.
module stall_mem_resp
  import stall_mem_pkg::*;
#(
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done
`ifdef MEM_ALIGN_CHK_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned CntW = cnt_width(LATENCY);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  mem_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q;
  logic [IdxW-1:0] idx_q;
  logic [15:0]     wdata_q;
  logic [15:0]     data_out_q, data_out_d;
  logic [15:0]     rdata;
  logic            accept, complete, bad, mem_we;
  logic [15:0]     unused_addr;

  assign unused_addr = addr;

  assign accept   = enable & (state_q != StBusy);
  assign complete = (state_q == StBusy) & (cnt_q == CntW'(1));

`ifdef MEM_ALIGN_CHK_EN
  logic mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= addr[0];
    end
  end

  assign bad = mis_q;
  assign err = (state_q == StDone) & mis_q;
`else
  assign bad = 1'b0;
`endif

  // Gate with rst so a write completing on a reset edge is aborted.
  assign mem_we = complete & wr_q & ~bad & ~rst;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = CntLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (complete) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!wr_q) data_out_d = bad ? 16'h0000 : rdata;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      data_out_q <= 16'h0000;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      if (accept) begin
        wr_q    <= wr;
        idx_q   <= addr[IdxW:1];
        wdata_q <= data_in;
      end
    end
  end

  stall_mem_array #(
    .Depth (DEPTH),
    .IdxW  (IdxW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  assign data_out = data_out_q;
  assign done     = (state_q == StDone);
  assign stall    = (state_q == StBusy) | accept;

endmodule
